if_id_instr_queue: RTL and testbench
====================================

Name: if_id_instr_queue

Overview:
- Parametrised IF/ID instruction buffer between fetch and decode.
- Replaces the single-entry stall/flush instruction select with a DEPTH-entry FIFO of {instr, pc} pairs.
- Decode reads the head. A flush, an empty queue, or a head fetched at the reset vector is presented to decode as a NOP.
- Adds a backpressure handshake to fetch and a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 32, instruction and PC width.
- DEPTH, 4, queue entries; power of 2, minimum 2.
- NOP_INSTR, 32'h0000_0033, encoding injected as a bubble (add x0,x0,x0).
- RESET_PC, 32'h1000_0000, PC whose instruction is replaced by NOP_INSTR at the head.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- fetch_valid  in  1  fetch presents an instruction this cycle.
- fetch_instr  in  XLEN  fetched instruction.
- fetch_pc  in  XLEN  PC of fetch_instr.
- fetch_ready  out  1  queue accepts a push this cycle.
- stall  in  1  decode holds; the head is not consumed.
- flush  in  1  discard all queued entries (branch/jump redirect).
- instr_d  out  XLEN  instruction to decode.
- pc_d  out  XLEN  PC of instr_d.
- valid_d  out  1  instr_d is a real queued entry.
- count  out  $clog2(DEPTH)+1  current occupancy.
- bubble_cnt  out  CNT_W  saturating count of NOP cycles delivered to decode.

Behaviour:
- Storage: DEPTH registered entries, plus wr_ptr and rd_ptr of width $clog2(DEPTH) that wrap modulo DEPTH, plus a registered count.
- Reset (reset_n=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, bubble_cnt=0.
  - Outputs while in reset: valid_d=0, instr_d=NOP_INSTR, pc_d=0, fetch_ready=0.
  - Entry contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately.
- fetch_ready = (count < DEPTH) && !flush && reset_n.
  - fetch_ready depends on registered state and flush only; there is no path from stall.
  - When full, no push is accepted even if a pop occurs in the same cycle.
- push = fetch_valid && fetch_ready. Writes entry[wr_ptr] and increments wr_ptr.
- pop = valid_d && !stall && !flush. Increments rd_ptr.
- count next state:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Latency: an entry pushed at edge N is visible at the head after edge N (1-cycle fetch-to-decode latency). There is no combinational bypass from fetch_instr to instr_d.
- Outputs (combinational from registered state and flush):
  - If flush=1: instr_d=NOP_INSTR, pc_d=0, valid_d=0.
  - Else if count=0: instr_d=NOP_INSTR, pc_d=0, valid_d=0.
  - Else if entry[rd_ptr].pc == RESET_PC: instr_d=NOP_INSTR, pc_d=RESET_PC, valid_d=1. The entry is consumed normally on pop.
  - Else: instr_d=entry[rd_ptr].instr, pc_d=entry[rd_ptr].pc, valid_d=1.
- Stall: head, pointers and outputs hold. Pushes continue while space remains.
- Flush:
  - At the next edge: rd_ptr=wr_ptr and count=0.
  - The push in the flush cycle is suppressed (fetch_ready=0).
  - Flush takes priority over stall.
  - The first post-flush entry is one pushed in a later cycle.
- bubble_cnt increments by 1 on each edge where stall=0 and (flush=1 or count=0 or the head pc == RESET_PC). It saturates at all-ones and never wraps.

Test Plan:
- Reset vector: release reset; push pc=1000_0000 instr=0000_0013, then pc=1000_0004 instr=0010_0093 -> cycle 1 instr_d=0000_0033 valid_d=1; cycle 2 instr_d=0010_0093 pc_d=1000_0004; bubble_cnt=2 (empty cycle + reset-vector head).
- Fill/full: stall=1, push 5 instructions back-to-back at DEPTH=4 -> count reaches 4, fetch_ready=0 on the 5th, and the 5th is not stored. Release stall -> heads emerge in order with 4 pops, then count=0.
- Flush: queue holds 3 entries; assert flush and fetch_valid for 1 cycle -> instr_d=0000_0033, valid_d=0, fetch_ready=0 that cycle; next cycle count=0; a subsequent push appears 1 cycle later.
- Flush over stall: stall=1 and flush=1 together with count=2 -> count=0 after the edge, valid_d=0.
- Wrap-around: stream 10 sequential PCs (0x0..0x24) with stall on alternate cycles -> decode sees all 10 in order with no loss or duplication across pointer wrap; simultaneous push+pop keeps count constant.
- Async reset mid-stream: assert reset_n=0 between edges with count=3 -> valid_d=0, count=0, bubble_cnt=0 immediately, without waiting for a clock edge; saturation check with CNT_W=4: 20 empty cycles -> bubble_cnt=15 and it holds there.

Source files
------------

// File: rtl/if_id_instr_queue.sv
// IF/ID instruction queue: a DEPTH-entry FIFO of {instr, pc} pairs between
// fetch and decode. Decode always sees the head; a flush, an empty queue, or a
// head whose PC equals the reset vector is presented as a NOP. Fetch gets a
// ready/valid handshake, and a saturating counter tracks bubbles sent to decode.
module if_id_instr_queue #(
  parameter int                XLEN      = 32,
  parameter int                DEPTH     = 4,
  parameter logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0033,
  parameter logic [XLEN-1:0]   RESET_PC  = 32'h1000_0000,
  parameter int                CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fetch_valid,
  input  logic [XLEN-1:0]            fetch_instr,
  input  logic [XLEN-1:0]            fetch_pc,
  output logic                       fetch_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic [XLEN-1:0]            instr_d,
  output logic [XLEN-1:0]            pc_d,
  output logic                       valid_d,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]  mem_instr_q [DEPTH];
  logic [XLEN-1:0]  mem_pc_q    [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic push;
  logic pop;
  logic empty;
  logic head_is_reset;
  logic bubble_inc;

  assign empty         = (count_q == '0);
  assign head_is_reset = (mem_pc_q[rd_ptr_q] == RESET_PC);

  // Accepting a push depends only on occupancy, flush and reset; stall has no
  // path here, and a full queue refuses a push even when a pop happens too.
  assign fetch_ready = (count_q < CW'(DEPTH)) && !flush && reset_n;
  assign push        = fetch_valid && fetch_ready;
  assign pop         = valid_d && !stall && !flush;

  // A bubble is a decode cycle that is not stalled and receives a NOP.
  assign bubble_inc  = !stall && (flush || empty || head_is_reset);

  // Decode-side view of the head, NOP-substituted for flush, empty and reset vector.
  always_comb begin
    instr_d = NOP_INSTR;
    pc_d    = '0;
    valid_d = 1'b0;
    if (!flush && !empty) begin
      valid_d = 1'b1;
      pc_d    = mem_pc_q[rd_ptr_q];
      if (!head_is_reset) begin
        instr_d = mem_instr_q[rd_ptr_q];
      end
    end
  end

  // Next-state for pointers, occupancy and the bubble counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    bubble_d = bubble_q;
    if (flush) begin
      // Push is already blocked by fetch_ready, so the queue simply drains.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    if (bubble_inc && !(&bubble_q)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // Control state with asynchronous reset; reset empties the queue at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bubble_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bubble_q <= bubble_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= fetch_instr;
      mem_pc_q[wr_ptr_q]    <= fetch_pc;
    end
  end

  assign count      = count_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_if_id_instr_queue.sv
// Directed bench for if_id_instr_queue with a 4-bit bubble counter so that
// saturation is reachable in a short run.
module tb_if_id_instr_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam logic [31:0] NOP  = 32'h0000_0033;
  localparam logic [31:0] RVEC = 32'h1000_0000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             fetch_valid;
  logic [XLEN-1:0]  fetch_instr;
  logic [XLEN-1:0]  fetch_pc;
  logic             fetch_ready;
  logic             stall;
  logic             flush;
  logic [XLEN-1:0]  instr_d;
  logic [XLEN-1:0]  pc_d;
  logic             valid_d;
  logic [2:0]       count;
  logic [CNT_W-1:0] bubble_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  if_id_instr_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP), .RESET_PC(RVEC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .stall(stall), .flush(flush),
    .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
    .count(count), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int sent;
    int got;
    int tb_cnt;
    logic exp_ready;
    logic do_push;
    logic do_pop;

    reset_n = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
    stall = 1'b0; flush = 1'b0;
    tick(); tick();
    settle();
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pc", pc_d, 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_bubble", 32'(bubble_cnt), 32'd0);

    // Reset-vector head is replaced by NOP but still counts as valid.
    reset_n = 1'b1;
    fetch_valid = 1'b1; fetch_pc = RVEC; fetch_instr = 32'h0000_0013;
    settle();
    chk("rv_empty_valid", 32'(valid_d), 32'd0);
    chk("rv_empty_instr", instr_d, NOP);
    chk("rv_ready", 32'(fetch_ready), 32'd1);
    tick();
    fetch_pc = 32'h1000_0004; fetch_instr = 32'h0010_0093;
    settle();
    chk("rv_head_instr", instr_d, NOP);
    chk("rv_head_pc", pc_d, RVEC);
    chk("rv_head_valid", 32'(valid_d), 32'd1);
    chk("rv_bubble1", 32'(bubble_cnt), 32'd1);
    tick();
    fetch_valid = 1'b0;
    settle();
    chk("rv2_instr", instr_d, 32'h0010_0093);
    chk("rv2_pc", pc_d, 32'h1000_0004);
    chk("rv2_bubble", 32'(bubble_cnt), 32'd2);
    chk("rv2_count", 32'(count), 32'd1);
    tick();
    settle();
    chk("rv_drained", 32'(count), 32'd0);

    // Fill under stall: 5th push refused, head held.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1'b1;
      fetch_pc    = 32'h100 + 32'(4 * i);
      fetch_instr = 32'hA000_0000 + 32'(i);
      settle();
      chk("fill_ready", 32'(fetch_ready), (i < DEPTH) ? 32'd1 : 32'd0);
      if (i > 0) chk("fill_head_hold", instr_d, 32'hA000_0000);
      tick();
    end
    fetch_valid = 1'b0;
    settle();
    chk("fill_count", 32'(count), 32'd4);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_instr", instr_d, 32'hA000_0000 + 32'(i));
      chk("drain_pc", pc_d, 32'h100 + 32'(4 * i));
      tick();
    end
    settle();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(valid_d), 32'd0);

    // Flush with 3 entries and a concurrent fetch.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1;
      fetch_pc    = 32'h200 + 32'(4 * i);
      fetch_instr = 32'hB000_0000 + 32'(i);
      tick();
    end
    flush = 1'b1; fetch_pc = 32'h300; fetch_instr = 32'hC000_0000;
    settle();
    chk("fl_instr", instr_d, NOP);
    chk("fl_valid", 32'(valid_d), 32'd0);
    chk("fl_ready", 32'(fetch_ready), 32'd0);
    chk("fl_count_before", 32'(count), 32'd3);
    tick();
    flush = 1'b0; stall = 1'b0; fetch_pc = 32'h400; fetch_instr = 32'hD000_0000;
    settle();
    chk("fl_count_after", 32'(count), 32'd0);
    chk("fl_valid_after", 32'(valid_d), 32'd0);
    tick();
    fetch_valid = 1'b0;
    settle();
    chk("fl_post_valid", 32'(valid_d), 32'd1);
    chk("fl_post_instr", instr_d, 32'hD000_0000);
    chk("fl_post_pc", pc_d, 32'h400);
    tick();

    // Flush wins over stall.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fetch_valid = 1'b1;
      fetch_pc    = 32'h500 + 32'(4 * i);
      fetch_instr = 32'hE000_0000 + 32'(i);
      tick();
    end
    fetch_valid = 1'b0; flush = 1'b1;
    settle();
    chk("fs_count_before", 32'(count), 32'd2);
    tick();
    flush = 1'b0;
    settle();
    chk("fs_count", 32'(count), 32'd0);
    chk("fs_valid", 32'(valid_d), 32'd0);
    stall = 1'b0;

    // Stream across pointer wrap with alternating stall and backpressure.
    sent = 0; got = 0; tb_cnt = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      stall       = c[0];
      fetch_valid = (sent < 10);
      fetch_pc    = 32'(sent * 4);
      fetch_instr = 32'hABC0_0000 + 32'(sent);
      settle();
      exp_ready = (tb_cnt < DEPTH);
      chk("wr_ready", 32'(fetch_ready), 32'(exp_ready));
      chk("wr_count", 32'(count), 32'(tb_cnt));
      chk("wr_valid", 32'(valid_d), 32'(tb_cnt > 0));
      do_push = fetch_valid && exp_ready;
      do_pop  = (tb_cnt > 0) && !stall;
      if (do_pop) begin
        chk("wr_pc", pc_d, 32'(got * 4));
        chk("wr_instr", instr_d, 32'hABC0_0000 + 32'(got));
        got++;
      end
      if (do_push) sent++;
      tb_cnt = tb_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      tick();
    end
    chk("wr_all_seen", 32'(got), 32'd10);
    fetch_valid = 1'b0; stall = 1'b0;
    settle();
    chk("wr_end_count", 32'(count), 32'd0);

    // Saturation before reset.
    repeat (20) tick();
    settle();
    chk("sat_pre", 32'(bubble_cnt), 32'd15);

    // Async reset between edges.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1;
      fetch_pc    = 32'h600 + 32'(4 * i);
      fetch_instr = 32'hF000_0000 + 32'(i);
      tick();
    end
    fetch_valid = 1'b0;
    settle();
    chk("ar_count_before", 32'(count), 32'd3);
    chk("ar_bubble_before", 32'(bubble_cnt), 32'd15);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(valid_d), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_bubble", 32'(bubble_cnt), 32'd0);
    chk("ar_ready", 32'(fetch_ready), 32'd0);
    chk("ar_instr", instr_d, NOP);
    #1;
    reset_n = 1'b1; stall = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("sat_cnt", 32'(bubble_cnt), (k < 15) ? 32'(k) : 32'd15);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
